video_frame_meter: RTL and testbench

Passive receiver at the output end of a de/hs/vs pixel stream, e.g. behind `filter_core_7x7` or any other filter core. Counts active pixels per line and active lines per frame, and checks every line against the first line of its frame. At each frame end it publishes width, height, error flags and a frame count. Synthesizable in-line checker for hardware and the self-checking sink for filter testbenches.

---
 rtl/video_frame_meter_if.sv | 24 ++
 rtl/video_frame_meter.sv | 114 +++++++++++
 tb/tb_video_frame_meter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/video_frame_meter_if.sv
// video_frame_meter_if: de/hs/vs pixel stream in, frame measurements out.
interface video_frame_meter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] di_i;
  logic                  de_i;
  logic                  hs_i;
  logic                  vs_i;
  logic [CNT_WIDTH-1:0]  width_o;
  logic [CNT_WIDTH-1:0]  height_o;
  logic [15:0]           frame_cnt_o;
  logic                  frame_done_o;
  logic [2:0]            err_o;
  logic [31:0]           csum_o;
  modport master (
    output di_i, de_i, hs_i, vs_i,
    input  width_o, height_o, frame_cnt_o, frame_done_o, err_o, csum_o
  );
  modport slave (
    input  di_i, de_i, hs_i, vs_i,
    output width_o, height_o, frame_cnt_o, frame_done_o, err_o, csum_o
  );
endinterface

// File: rtl/video_frame_meter.sv
// video_frame_meter: measures width/height/consistency of each de/hs/vs frame.
// Optional pixel checksum on csum_o when VIDEO_FRAME_METER_CSUM_EN is defined.
module video_frame_meter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  video_frame_meter_if.slave bus
);
  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [1:0]           r_state;
  logic                 r_hs_q, r_vs_q;
  logic [CNT_WIDTH-1:0] r_pix, r_line, r_ref, r_width, r_height;
  logic                 r_mis, r_sync, r_ovf, r_idle_err, r_done;
  logic [2:0]           r_err;
  logic [15:0]          r_frame_cnt;
  logic                 w_line_end, w_fs, w_fe, w_in_frame, w_pix_ovf, w_close;
  logic                 w_first, w_line_ovf, w_mis, w_sync, w_ovf;
  logic [CNT_WIDTH-1:0] w_pix, w_line, w_ref;
  assign w_line_end = bus.hs_i & ~r_hs_q;
  assign w_fs       = bus.vs_i & ~r_vs_q;
  assign w_fe       = ~bus.vs_i & r_vs_q;
  assign w_in_frame = r_state == S_FRAME;
  assign w_pix_ovf  = bus.de_i & (r_pix == CNT_MAX);
  assign w_pix      = (bus.de_i & ~w_pix_ovf) ? r_pix + 1'b1 : r_pix;
  // A frame end also closes a line still holding pixels
  assign w_close    = w_in_frame & (w_line_end | w_fe) & (w_pix != '0);
  assign w_first    = r_line == '0;
  assign w_line_ovf = w_close & (r_line == CNT_MAX);
  assign w_line     = (w_close & ~w_line_ovf) ? r_line + 1'b1 : r_line;
  assign w_ref      = (w_close & w_first) ? w_pix : r_ref;
  assign w_mis      = r_mis | (w_close & ~w_first & (w_pix != r_ref));
  assign w_sync     = r_sync | (bus.de_i & bus.hs_i);
  assign w_ovf      = r_ovf | w_pix_ovf | w_line_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_hs_q      <= 1'b0;
      r_vs_q      <= 1'b0;
      r_pix       <= '0;
      r_line      <= '0;
      r_ref       <= '0;
      r_mis       <= 1'b0;
      r_sync      <= 1'b0;
      r_ovf       <= 1'b0;
      r_idle_err  <= 1'b0;
      r_width     <= '0;
      r_height    <= '0;
      r_err       <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_hs_q <= bus.hs_i;
      r_vs_q <= bus.vs_i;
      r_done <= 1'b0;
      if (r_state == S_SYNC) begin
        if (!bus.vs_i) r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        // Pixels seen between frames are charged to the next frame's sync flag
        r_idle_err <= w_fs ? 1'b0 : r_idle_err | bus.de_i;
        if (w_fs) begin
          r_pix   <= '0;
          r_line  <= '0;
          r_ref   <= '0;
          r_mis   <= 1'b0;
          r_ovf   <= 1'b0;
          r_sync  <= r_idle_err | bus.de_i;
          r_state <= S_FRAME;
        end
      end else begin
        r_pix  <= w_close ? '0 : w_pix;
        r_line <= w_line;
        r_ref  <= w_ref;
        r_mis  <= w_mis;
        r_sync <= w_sync;
        r_ovf  <= w_ovf;
        if (w_fe) begin
          r_width     <= w_ref;
          r_height    <= w_line;
          r_err       <= {w_ovf, w_sync, w_mis};
          r_frame_cnt <= r_frame_cnt + 1'b1;
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
      end
    end
  end
  assign bus.width_o      = r_width;
  assign bus.height_o     = r_height;
  assign bus.frame_cnt_o  = r_frame_cnt;
  assign bus.frame_done_o = r_done;
  assign bus.err_o        = r_err;
`ifdef VIDEO_FRAME_METER_CSUM_EN
  logic [31:0] r_acc, r_csum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_csum <= '0;
    end else if (r_state == S_IDLE && w_fs) begin
      r_acc <= '0;
    end else if (w_in_frame) begin
      r_acc <= bus.de_i ? r_acc + 32'(bus.di_i) : r_acc;
      if (w_fe) r_csum <= bus.de_i ? r_acc + 32'(bus.di_i) : r_acc;
    end
  end
  assign bus.csum_o = r_csum;
`else
  assign bus.csum_o = '0;
`endif
endmodule

// File: tb/tb_video_frame_meter.sv
// tb_video_frame_meter: table-driven and randomized frames against a line-list model.
module tb_video_frame_meter;
  typedef struct {
    int nl, w, sidx, slen, gap, merge, blank;
    bit idle, hsde;
    int ew, eh, eerr;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0, bad = 0, n_done = 0;
  int exp_cnt = 0;
  int g_lens[$];
  int g_sum, g_gap, g_merge, g_blank;
  bit g_idle, g_hsde, g_rnd;
  vec_t tv[9];
  always #5 clk = ~clk;
  video_frame_meter_if vif();
  video_frame_meter dut (.clk(clk), .rst(rst), .bus(vif.slave));
  always @(negedge clk) if (vif.frame_done_o) n_done++;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_frame();
    vif.de_i = 1'b0; vif.hs_i = 1'b1; vif.vs_i = 1'b0; vif.di_i = '0;
    g_sum = 0;
    repeat (3) step();
    if (g_idle) begin vif.de_i = 1'b1; step(); vif.de_i = 1'b0; end
    step();
    vif.vs_i = 1'b1;
    repeat (2) step();
    foreach (g_lens[l]) begin
      vif.hs_i = 1'b0;
      if (g_lens[l] == 0) step();
      for (int x = 0; x < g_lens[l]; x++) begin
        vif.de_i = 1'b1;
        vif.di_i = g_rnd ? 8'($urandom) : 8'(x);
        g_sum += int'(vif.di_i);
        step();
        vif.de_i = 1'b0; vif.di_i = '0;
        repeat (g_gap) step();
      end
      if (l == g_lens.size() - 1 && g_merge != 0) begin
        vif.hs_i = (g_merge == 1); vif.vs_i = 1'b0;
        step();
        vif.hs_i = 1'b1;
      end else begin
        vif.hs_i = 1'b1;
        for (int b = 0; b < g_blank; b++) begin
          vif.de_i = g_hsde && l == 0 && b == 1;
          step();
        end
        vif.de_i = 1'b0;
      end
    end
    if (g_merge == 0) begin vif.vs_i = 1'b0; step(); end
  endtask
  task automatic check_frame(input string nm, input int ew, input int eh, input int eerr);
    exp_cnt = (exp_cnt + 1) % 65536;
    check({nm, ".done"}, 32'(vif.frame_done_o), 32'd1);
    check({nm, ".width"}, 32'(vif.width_o), ew);
    check({nm, ".height"}, 32'(vif.height_o), eh);
    check({nm, ".err"}, 32'(vif.err_o), eerr);
    check({nm, ".cnt"}, 32'(vif.frame_cnt_o), exp_cnt);
`ifdef VIDEO_FRAME_METER_CSUM_EN
    check({nm, ".csum"}, vif.csum_o, g_sum);
`else
    check({nm, ".csum"}, vif.csum_o, 32'd0);
`endif
    step();
    check({nm, ".pulse1"}, 32'(vif.frame_done_o), 32'd0);
  endtask
  initial begin
    int mw, mh, me;
    tv[0] = '{24, 24, -1, 0, 0, 1, 170, 0, 0, 24, 24, 0};
    tv[1] = '{24, 24, -1, 0, 0, 1, 170, 0, 0, 24, 24, 0};
    tv[2] = '{24, 24, -1, 0, 1, 1, 20, 0, 0, 24, 24, 0};
    tv[3] = '{24, 24, 4, 23, 0, 1, 20, 0, 0, 24, 24, 1};
    tv[4] = '{24, 24, -1, 0, 0, 1, 20, 0, 0, 24, 24, 0};
    tv[5] = '{4, 3, -1, 0, 0, 0, 6, 0, 1, 3, 4, 3};
    tv[6] = '{4, 3, -1, 0, 0, 0, 6, 1, 0, 3, 4, 2};
    tv[7] = '{5, 6, 0, 0, 0, 1, 8, 0, 0, 6, 4, 0};
    tv[8] = '{3, 5, -1, 0, 0, 2, 8, 0, 0, 5, 3, 0};
    rst = 1'b1;
    vif.de_i = 1'b0; vif.hs_i = 1'b1; vif.vs_i = 1'b0; vif.di_i = '0;
    repeat (3) step();
    check("rst.width", 32'(vif.width_o), 0);
    check("rst.height", 32'(vif.height_o), 0);
    check("rst.cnt", 32'(vif.frame_cnt_o), 0);
    check("rst.err", 32'(vif.err_o), 0);
    check("rst.done", 32'(vif.frame_done_o), 0);
    check("rst.csum", vif.csum_o, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      g_lens.delete();
      for (int l = 0; l < tv[i].nl; l++) g_lens.push_back(l == tv[i].sidx ? tv[i].slen : tv[i].w);
      g_gap = tv[i].gap; g_merge = tv[i].merge; g_blank = tv[i].blank;
      g_idle = tv[i].idle; g_hsde = tv[i].hsde; g_rnd = 1'b0;
      drive_frame();
`ifdef VIDEO_FRAME_METER_CSUM_EN
      if (i == 0) check("tv0.csum6624", vif.csum_o, 32'd6624);
`endif
      check_frame($sformatf("tv%0d", i), tv[i].ew, tv[i].eh, tv[i].eerr);
    end
    // Reset in the middle of a frame: that frame must never be reported
    g_lens.delete();
    repeat (24) g_lens.push_back(24);
    g_gap = 0; g_merge = 1; g_blank = 20; g_idle = 0; g_hsde = 0; g_rnd = 1'b0;
    vif.vs_i = 1'b1;
    repeat (2) step();
    for (int l = 0; l < 3; l++) begin
      vif.hs_i = 1'b0; vif.de_i = 1'b1;
      repeat (24) step();
      vif.hs_i = 1'b1; vif.de_i = 1'b0;
      repeat (20) step();
    end
    #2 rst = 1'b1;
    #1;
    check("midrst.width", 32'(vif.width_o), 0);
    check("midrst.cnt", 32'(vif.frame_cnt_o), 0);
    check("midrst.err", 32'(vif.err_o), 0);
    check("midrst.done", 32'(vif.frame_done_o), 0);
    rst = 1'b0;
    exp_cnt = 0;
    for (int l = 0; l < 3; l++) begin
      vif.hs_i = 1'b0; vif.de_i = 1'b1;
      repeat (24) step();
      vif.hs_i = 1'b1; vif.de_i = 1'b0;
      repeat (20) step();
    end
    begin
      int n0;
      n0 = n_done;
      drive_frame();
      check_frame("after_rst", 24, 24, 0);
      check("after_rst.pulses", n_done, n0 + 1);
    end
    for (int i = 0; i < 25; i++) begin
      int base;
      g_lens.delete();
      base = $urandom_range(1, 8);
      for (int l = $urandom_range(1, 6); l > 0; l--) begin
        int r;
        r = $urandom_range(0, 9);
        g_lens.push_back(r == 0 ? 0 : r == 1 ? $urandom_range(1, 8) : base);
      end
      g_gap = $urandom_range(0, 1); g_merge = $urandom_range(0, 2); g_blank = $urandom_range(3, 6);
      g_idle = ($urandom_range(0, 4) == 0); g_hsde = 0; g_rnd = 1'b1;
      mw = 0; mh = 0; me = 0;
      foreach (g_lens[l]) if (g_lens[l] != 0) begin
        if (mh == 0) mw = g_lens[l];
        else if (g_lens[l] != mw) me = 1;
        mh++;
      end
      drive_frame();
      check_frame($sformatf("rnd%0d", i), mw, mh, me | (g_idle ? 2 : 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
